// File: rtl/clock_set_ctrl_if.sv
// Button, strobe and counter-control signals between the time-setting
// controller (master) and its surroundings: prescaler, buttons and the
// hour/minute/second counter chain (slave).
interface clock_set_ctrl_if;
  logic       SMP_EN;
  logic       EN1HZ;
  logic       BTN_MODE;
  logic       BTN_UP;
  logic       SEC_EN;
  logic       SEC_CLR;
  logic       HOUR_INC;
  logic       MIN_INC;
  logic       BLANK_H;
  logic       BLANK_M;
  logic [1:0] MODE;

  modport master (
    input  SMP_EN, EN1HZ, BTN_MODE, BTN_UP,
    output SEC_EN, SEC_CLR, HOUR_INC, MIN_INC, BLANK_H, BLANK_M, MODE
  );

  modport slave (
    output SMP_EN, EN1HZ, BTN_MODE, BTN_UP,
    input  SEC_EN, SEC_CLR, HOUR_INC, MIN_INC, BLANK_H, BLANK_M, MODE
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces MODE/UP, runs the RUN/SET_HOUR/SET_MIN
// FSM, freezes seconds while setting, issues hour/minute increment pulses
// with hold auto-repeat, and blinks the digit being set.

// Per-button synchroniser + debouncer; level moves only after DEB_N
// consecutive differing samples.
module clock_set_deb #(
  parameter int DEB_N = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic smp_en,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEB_N + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser, then a run-length counter on sample strobes
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (smp_en) begin
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_N - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

module clock_set_ctrl #(
  parameter int DEB_N      = 20,
  parameter int REP_DLY    = 500,
  parameter int REP_PER    = 100,
  parameter int BLINK_HALF = 250,
  parameter int TIMEOUT    = 30000
) (
  input logic              CLK,
  input logic              RST,
  clock_set_ctrl_if.master bus
);
  localparam int NUM_BTN = 2;  // bit 0 = MODE, bit 1 = UP
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2((REP_DLY > REP_PER ? REP_DLY : REP_PER) + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  logic [NUM_BTN-1:0] raw, lvl, lvl_q, press;
  state_t             state, next;
  logic [TW-1:0]      to_cnt;
  logic [RW-1:0]      rep_cnt;
  logic               rep_arm, rep_first;
  logic [BW-1:0]      bl_cnt;
  logic               phase;
  logic               sec_clr, hour_inc, min_inc;
  logic               set_st, chg, timeout, rep_fire, up_ok, inc_req;
  logic               mode_press, up_press, up_lvl;

  assign raw = {bus.BTN_UP, bus.BTN_MODE};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    clock_set_deb #(.DEB_N(DEB_N)) u_deb (
      .CLK   (CLK),
      .RST   (RST),
      .smp_en(bus.SMP_EN),
      .raw   (raw[i]),
      .level (lvl[i])
    );
  end

  // A press is high during the first cycle a debounced level reads 1
  assign press      = lvl & ~lvl_q;
  assign mode_press = press[0];
  assign up_press   = press[1];
  assign up_lvl     = lvl[1];

  // Next state, timeout and increment requests; MODE beats UP and timeout
  always_comb begin
    set_st  = (state != RUN);
    timeout = set_st && bus.SMP_EN && (to_cnt == TW'(TIMEOUT - 1));
    next    = state;
    case (state)
      RUN:      if (mode_press) next = SET_HOUR;
      SET_HOUR: if (mode_press) next = SET_MIN;
                else if (timeout) next = RUN;
      SET_MIN:  if (mode_press || timeout) next = RUN;
      default:  next = RUN;
    endcase
    chg      = (next != state);
    rep_fire = rep_arm && up_lvl && bus.SMP_EN &&
               (rep_first ? (rep_cnt == RW'(REP_PER - 1))
                          : (rep_cnt == RW'(REP_DLY - 1)));
    // No increment in a cycle that changes state, so a simultaneous press is dropped
    up_ok    = set_st && !chg && up_press;
    inc_req  = up_ok || (set_st && !chg && rep_fire);
  end

  // State register, press edge history and the registered pulse outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= RUN;
      lvl_q    <= '0;
      sec_clr  <= 1'b0;
      hour_inc <= 1'b0;
      min_inc  <= 1'b0;
    end else begin
      state    <= next;
      lvl_q    <= lvl;
      sec_clr  <= set_st && (next == RUN);
      hour_inc <= inc_req && (state == SET_HOUR);
      min_inc  <= inc_req && (state == SET_MIN);
    end
  end

  // Inactivity timer in set states; any press or state change restarts it
  always_ff @(posedge CLK) begin
    if (!RST)                                to_cnt <= '0;
    else if (!set_st || chg || (|press))     to_cnt <= '0;
    else if (bus.SMP_EN)                     to_cnt <= to_cnt + TW'(1);
  end

  // Auto-repeat: armed only by an accepted UP press, dropped on release or mode change
  always_ff @(posedge CLK) begin
    if (!RST || !set_st || chg || !up_lvl) begin
      rep_arm   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (up_ok) begin
      rep_arm   <= 1'b1;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_arm && bus.SMP_EN) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

  // Blink phase; restarts visible on entry and after every increment
  always_ff @(posedge CLK) begin
    if (!RST || !set_st || chg || inc_req) begin
      phase  <= 1'b0;
      bl_cnt <= '0;
    end else if (bus.SMP_EN) begin
      if (bl_cnt == BW'(BLINK_HALF - 1)) begin
        phase  <= ~phase;
        bl_cnt <= '0;
      end else begin
        bl_cnt <= bl_cnt + BW'(1);
      end
    end
  end

  assign bus.SEC_EN   = bus.EN1HZ && (state == RUN) && !sec_clr;
  assign bus.SEC_CLR  = sec_clr;
  assign bus.HOUR_INC = hour_inc;
  assign bus.MIN_INC  = min_inc;
  assign bus.BLANK_H  = (state == SET_HOUR) && phase;
  assign bus.BLANK_M  = (state == SET_MIN) && phase;
  assign bus.MODE     = state;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: expected SEC_CLR/HOUR_INC/MIN_INC events are
// queued as stimulus is applied and matched as the DUT emits them.
module tb_clock_set_ctrl;
  localparam int DEB_N = 3, REP_DLY = 8, REP_PER = 4, BLINK_HALF = 5, TIMEOUT = 40;
  localparam logic [2:0] EV_CLR = 3'b100, EV_H = 3'b010, EV_M = 3'b001;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic en1hz_on = 1'b0;
  int   smp_div = 0, sec_div = 0;
  int   n_cmp = 0, n_bad = 0;
  int   n_en1hz = 0, n_secen = 0, n_secbad = 0, n_clr = 0, n_inc = 0;
  logic [2:0] sb_q[$];

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .DEB_N(DEB_N), .REP_DLY(REP_DLY), .REP_PER(REP_PER),
    .BLINK_HALF(BLINK_HALF), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Prescaler model: SMP_EN every 4 cycles, EN1HZ every 50 when enabled
  initial begin
    bus.SMP_EN = 1'b0;
    bus.EN1HZ  = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      smp_div    = (smp_div + 1) % 4;
      bus.SMP_EN = (smp_div == 0);
      if (en1hz_on) begin
        sec_div   = (sec_div + 1) % 50;
        bus.EN1HZ = (sec_div == 0);
      end else begin
        sec_div   = 0;
        bus.EN1HZ = 1'b0;
      end
    end
  end

  // Output monitor: strobe bookkeeping and scoreboard matching
  always @(negedge CLK) begin
    logic [2:0] ev;
    ev = {bus.SEC_CLR, bus.HOUR_INC, bus.MIN_INC};
    if (bus.EN1HZ === 1'b1) n_en1hz++;
    if (bus.SEC_EN === 1'b1) n_secen++;
    if (bus.SEC_EN === 1'b1 && bus.EN1HZ !== 1'b1) n_secbad++;
    if (bus.SEC_CLR === 1'b1) n_clr++;
    if (bus.HOUR_INC === 1'b1 || bus.MIN_INC === 1'b1) n_inc++;
    if (ev != 3'b000) begin
      if (sb_q.size() == 0) chk("unexpected_event", 32'(ev), 0);
      else chk("event", 32'(ev), 32'(sb_q.pop_front()));
      if (bus.HOUR_INC || bus.MIN_INC)
        chk("blank_at_inc", {bus.BLANK_H, bus.BLANK_M}, 0);
    end
  end

  task automatic wait_smp(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge CLK);
      if (bus.SMP_EN) k++;
    end
    #1;
  endtask

  task automatic wait_mode(input logic [1:0] m, input string tag);
    for (int k = 0; k < 200 && bus.MODE !== m; k++) begin
      @(posedge CLK);
      #1;
    end
    chk(tag, bus.MODE, m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_en, b_sec, b_inc, b_clr;
    bus.BTN_MODE = 1'b0;
    bus.BTN_UP   = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", {bus.MODE, bus.SEC_EN, bus.SEC_CLR, bus.HOUR_INC,
                       bus.MIN_INC, bus.BLANK_H, bus.BLANK_M}, 0);
    RST = 1'b1;

    // Idle RUN: SEC_EN mirrors EN1HZ
    en1hz_on = 1'b1;
    b_en = n_en1hz; b_sec = n_secen;
    repeat (200) @(posedge CLK);
    #1;
    chk("run_en1hz_seen", 32'((n_en1hz - b_en) >= 3), 1);
    chk("run_sec_en_mirror", n_secen - b_sec, n_en1hz - b_en);
    chk("run_idle_outs", {bus.MODE, bus.BLANK_H, bus.BLANK_M, bus.HOUR_INC, bus.MIN_INC}, 0);

    // Bouncing MODE then held: exactly one press
    b_en = n_en1hz; b_sec = n_secen;
    bus.BTN_MODE = 1'b1; wait_smp(1); bus.BTN_MODE = 1'b0; wait_smp(1);
    bus.BTN_MODE = 1'b1; wait_smp(1); bus.BTN_MODE = 1'b0; wait_smp(1);
    chk("bounce_no_press", bus.MODE, 2'b00);
    bus.BTN_MODE = 1'b1;
    wait_mode(2'b01, "mode_to_set_hour");
    bus.BTN_MODE = 1'b0;

    // Blink: visible for 5 samples, blank for 5
    wait_smp(4); chk("blink_s4", bus.BLANK_H, 0);
    wait_smp(1); chk("blink_s5", bus.BLANK_H, 1);
    chk("blank_m_in_hour", bus.BLANK_M, 0);
    wait_smp(4); chk("blink_s9", bus.BLANK_H, 1);
    wait_smp(1); chk("blink_s10", bus.BLANK_H, 0);

    // Three UP taps in SET_HOUR
    for (int t = 0; t < 3; t++) begin
      sb_q.push_back(EV_H);
      bus.BTN_UP = 1'b1; wait_smp(5);
      bus.BTN_UP = 1'b0; wait_smp(5);
    end
    chk("hour_taps_done", sb_q.size(), 0);
    chk("set_sec_frozen", n_secen - b_sec, 0);
    chk("set_en1hz_seen", 32'((n_en1hz - b_en) >= 1), 1);
    chk("still_set_hour", bus.MODE, 2'b01);

    // SET_MIN with UP held: press + repeats at 8,12,16,20 samples
    bus.BTN_MODE = 1'b1;
    wait_mode(2'b10, "mode_to_set_min");
    bus.BTN_MODE = 1'b0;
    wait_smp(4);
    for (int i = 0; i < 5; i++) sb_q.push_back(EV_M);
    bus.BTN_UP = 1'b1;
    for (int k = 0; k < 200 && bus.MIN_INC !== 1'b1; k++) begin
      @(posedge CLK);
      #1;
    end
    chk("min_first_inc", bus.MIN_INC, 1);
    wait_smp(18);
    bus.BTN_UP = 1'b0;
    wait_smp(6);
    chk("min_hold_pulses", sb_q.size(), 0);

    // MODE back to RUN: one SEC_CLR, SEC_EN resumes
    sb_q.push_back(EV_CLR);
    bus.BTN_MODE = 1'b1;
    wait_mode(2'b00, "mode_to_run");
    bus.BTN_MODE = 1'b0;
    b_en = n_en1hz; b_sec = n_secen;
    repeat (120) @(posedge CLK);
    #1;
    chk("sec_clr_on_mode", sb_q.size(), 0);
    chk("resume_en1hz_seen", 32'((n_en1hz - b_en) >= 2), 1);
    chk("resume_sec_en_mirror", n_secen - b_sec, n_en1hz - b_en);

    // Idle SET_HOUR times out after 40 samples
    bus.BTN_MODE = 1'b1;
    wait_mode(2'b01, "mode_to_set_hour_2");
    bus.BTN_MODE = 1'b0;
    sb_q.push_back(EV_CLR);
    wait_smp(36); chk("timeout_not_yet", bus.MODE, 2'b01);
    wait_smp(8);  chk("timeout_to_run", bus.MODE, 2'b00);
    chk("sec_clr_on_timeout", sb_q.size(), 0);

    // MODE and UP together in SET_HOUR: MODE wins, no INC, no repeat
    wait_smp(2);
    bus.BTN_MODE = 1'b1;
    wait_mode(2'b01, "mode_to_set_hour_3");
    bus.BTN_MODE = 1'b0;
    wait_smp(5);
    b_inc = n_inc;
    bus.BTN_MODE = 1'b1;
    bus.BTN_UP   = 1'b1;
    wait_mode(2'b10, "mode_up_together");
    bus.BTN_MODE = 1'b0;
    wait_smp(REP_DLY + 8);
    bus.BTN_UP = 1'b0;
    wait_smp(5);
    chk("mode_wins_no_inc", n_inc - b_inc, 0);
    sb_q.push_back(EV_M);
    bus.BTN_UP = 1'b1; wait_smp(5);
    bus.BTN_UP = 1'b0; wait_smp(2);
    chk("min_after_repress", sb_q.size(), 0);

    // Reset in SET_MIN: outputs clear next cycle, no SEC_CLR
    en1hz_on = 1'b0;
    wait_smp(1);
    chk("pre_reset_mode", bus.MODE, 2'b10);
    b_clr = n_clr;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("midset_reset_outs", {bus.MODE, bus.SEC_EN, bus.SEC_CLR, bus.HOUR_INC,
                              bus.MIN_INC, bus.BLANK_H, bus.BLANK_M}, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    chk("no_sec_clr_on_reset", n_clr - b_clr, 0);
    chk("after_reset_mode", bus.MODE, 2'b00);
    chk("sec_en_only_with_en1hz", n_secbad, 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
